stdin_read_arbiter: RTL and testbench



---
 rtl/stdin_read_arbiter.sv | 158 +++++++++++++++
 tb/tb_stdin_read_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stdin_read_arbiter.sv
// Round-robin arbiter that shares one byte-wide stdin source among NREQ consumers.
// It has a response watchdog, and end-of-file and timeout are sticky flags.
module stdin_read_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [7:0]      rd_data,
  output logic [NREQ-1:0] rd_valid,
  output logic            rd_eof,
  output logic            timeout,
  output logic            src_rd,
  input  logic [7:0]      src_data,
  input  logic            src_valid,
  input  logic            src_eof,
  output logic [1:0]      dbg_state
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: src_rd is a one-cycle strobe. The source answers with src_valid
  // and/or src_eof for one cycle, starting no earlier than the cycle after the
  // strobe. rd_valid is a one-cycle push to the owner and has no back-pressure.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_EOF   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic [NREQ-1:0] rd_valid_q, rd_valid_d;
  logic            rd_eof_q, rd_eof_d;
  logic            timeout_q, timeout_d;
  logic            src_rd_q, src_rd_d;
  logic [LW-1:0]   last_q, last_d;
  logic [LW-1:0]   owner_q, owner_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [LW-1:0]   pick_idx;
  logic            pick_found;
  int              cand;

  // The scan starts one past the last served requester and wraps around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(last_q) + 1 + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!pick_found && req[LW'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = LW'(cand);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = '0;
    rd_eof_d   = rd_eof_q;
    timeout_d  = timeout_q;
    src_rd_d   = 1'b0;
    last_d     = last_q;
    owner_d    = owner_q;
    timer_d    = timer_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d  = NREQ'(1) << pick_idx;
          owner_d  = pick_idx;
          src_rd_d = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (src_valid) begin
          rd_data_d  = src_data;
          rd_valid_d = grant_q;
          last_d     = owner_q;
          grant_d    = '0;
          if (src_eof) begin
            rd_eof_d = 1'b1;
            state_d  = S_EOF;
          end else begin
            state_d  = S_IDLE;
          end
        end else if (src_eof) begin
          // 8'hFF is the low byte of the -1 end-of-file code.
          rd_data_d  = 8'hFF;
          rd_valid_d = grant_q;
          rd_eof_d   = 1'b1;
          grant_d    = '0;
          state_d    = S_EOF;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          // last is left untouched, so the same requester wins the retry.
          timeout_d = 1'b1;
          grant_d   = '0;
          state_d   = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_EOF: begin
        grant_d  = '0;
        rd_eof_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
      rd_eof_q   <= 1'b0;
      timeout_q  <= 1'b0;
      src_rd_q   <= 1'b0;
      last_q     <= LW'(NREQ - 1);
      owner_q    <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_eof_q   <= rd_eof_d;
      timeout_q  <= timeout_d;
      src_rd_q   <= src_rd_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      timer_q    <= timer_d;
    end
  end

  assign grant     = grant_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_eof    = rd_eof_q;
  assign timeout   = timeout_q;
  assign src_rd    = src_rd_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_stdin_read_arbiter.sv
// Bench for stdin_read_arbiter: a reactive stdin source plus scenario tasks,
// including a randomized run that is checked against a round-robin reference model.
module tb_stdin_read_arbiter;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 16;
  localparam int TW      = 5;

  logic            clk, rst_n;
  logic [NREQ-1:0] req, grant, rd_valid;
  logic [7:0]      rd_data, src_data;
  logic            rd_eof, timeout, src_rd, src_valid, src_eof;
  logic [1:0]      dbg_state;

  int checks = 0;
  int errors = 0;

  // Source behaviour for the next strobe: 0 byte, 1 eof only, 2 byte+eof, 3 silent.
  int         src_mode  = 3;
  int         src_delay = 0;
  logic [7:0] src_byte  = 8'h00;

  stdin_read_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .CLK(clk), .RST_N(rst_n), .req(req), .grant(grant), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_eof(rd_eof), .timeout(timeout), .src_rd(src_rd),
    .src_data(src_data), .src_valid(src_valid), .src_eof(src_eof),
    .dbg_state(dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Source model: answers (1 + src_delay) cycles after it sees the strobe.
  // It deliberately ignores reset, so a late answer can land after a reset.
  initial begin : source_model
    int         cnt;
    int         mode;
    logic [7:0] b;
    cnt = 0; mode = 3; b = 8'h00;
    src_valid = 1'b0; src_eof = 1'b0; src_data = 8'h00;
    forever begin
      @(negedge clk);
      src_valid = 1'b0; src_eof = 1'b0; src_data = 8'h00;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          case (mode)
            0: begin src_valid = 1'b1; src_data = b; end
            1: src_eof = 1'b1;
            2: begin src_valid = 1'b1; src_eof = 1'b1; src_data = b; end
            default: ;
          endcase
        end
      end
      if (src_rd === 1'b1) begin
        cnt  = 1 + src_delay;
        mode = src_mode;
        b    = src_byte;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference round-robin: first requester after 'last', wrapping around.
  function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
    int rv;
    int idx;
    rv = int'(r);
    for (int k = 1; k <= NREQ; k++) begin
      idx = (last + k) % NREQ;
      if (((rv >> idx) & 1) != 0) return idx;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    src_mode = 3;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    req = '0;
    repeat (3) @(negedge clk);
    checks++; if (grant !== '0) begin errors++; $display("FAIL reset_grant got=%b exp=0", grant); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
    checks++; if (rd_valid !== '0) begin errors++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (rd_eof !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL reset_flags eof=%b timeout=%b exp 0 0", rd_eof, timeout); end
    checks++; if (src_rd !== 1'b0) begin errors++; $display("FAIL reset_src_rd got=%b exp=0", src_rd); end
    rst_n = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (grant !== '0 || src_rd !== 1'b0 || rd_valid !== '0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_no_req bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_single();
    logic [1:0] idle_st;
    do_reset();
    idle_st = dbg_state;
    src_mode = 0; src_delay = 0; src_byte = 8'h41;
    req = 2'b01;
    @(negedge clk);
    checks++; if (grant !== 2'b01 || src_rd !== 1'b1) begin errors++; $display("FAIL single_grant grant=%b src_rd=%b exp 01 1", grant, src_rd); end
    checks++; if (dbg_state === idle_st) begin errors++; $display("FAIL single_state state=%0d still idle value %0d", dbg_state, idle_st); end
    req = 2'b00;  // dropping the request must not abort the transaction
    @(negedge clk);
    checks++; if (grant !== 2'b01 || src_rd !== 1'b0) begin errors++; $display("FAIL single_wait grant=%b src_rd=%b exp 01 0", grant, src_rd); end
    @(negedge clk);
    checks++; if (rd_valid !== 2'b01 || rd_data !== 8'h41 || grant !== 2'b00) begin
      errors++; $display("FAIL single_deliver rd_valid=%b rd_data=%h grant=%b exp 01 41 00", rd_valid, rd_data, grant);
    end
    @(negedge clk);
    checks++; if (rd_valid !== 2'b00 || grant !== 2'b00 || src_rd !== 1'b0) begin
      errors++; $display("FAIL single_after rd_valid=%b grant=%b src_rd=%b exp 00 00 0", rd_valid, grant, src_rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]      bytes [4];
    logic [NREQ-1:0] exp_g [4];
    bytes = '{8'h61, 8'h62, 8'h63, 8'h64};
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      src_mode = 0; src_delay = 0; src_byte = bytes[i];
      @(negedge clk);
      checks++; if (grant !== exp_g[i] || src_rd !== 1'b1) begin
        errors++; $display("FAIL b2b_grant i=%0d grant=%b src_rd=%b exp %b 1", i, grant, src_rd, exp_g[i]);
      end
      @(negedge clk);
      checks++; if (src_rd !== 1'b0) begin errors++; $display("FAIL b2b_one_strobe i=%0d src_rd=%b exp 0", i, src_rd); end
      @(negedge clk);
      checks++; if (rd_valid !== exp_g[i] || rd_data !== bytes[i]) begin
        errors++; $display("FAIL b2b_deliver i=%0d rd_valid=%b rd_data=%h exp %b %h", i, rd_valid, rd_data, exp_g[i], bytes[i]);
      end
    end
    req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_random(input int n);
    int              last_m, w, d, lat, bad, nrd;
    logic [NREQ-1:0] r, eg;
    logic [7:0]      b;
    int              tx_err;
    do_reset();
    last_m = NREQ - 1;
    tx_err = 0;
    for (int t = 0; t < n; t++) begin
      r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      d = $urandom_range(0, 5);
      b = 8'($urandom);
      src_mode = 0; src_delay = d; src_byte = b;
      req = r;
      w = rr_pick(r, last_m);
      eg = NREQ'(1 << w);
      @(negedge clk);
      checks++; if (grant !== eg || src_rd !== 1'b1) begin
        errors++; $display("FAIL rand_grant t=%0d req=%b grant=%b src_rd=%b exp %b 1", t, r, grant, src_rd, eg);
      end
      req = NREQ'($urandom);  // mid-transaction request changes must not matter
      bad = 0; nrd = 0; lat = 0;
      do begin
        @(negedge clk);
        lat++;
        if (rd_valid === '0) begin
          if (grant !== eg) bad++;
          if (src_rd !== 1'b0) nrd++;
        end
      end while (rd_valid === '0 && lat < TIMEOUT + 4);
      checks++; if (lat != d + 2) begin errors++; $display("FAIL rand_latency t=%0d got=%0d exp=%0d", t, lat, d + 2); end
      checks++; if (rd_valid !== eg || rd_data !== b) begin
        errors++; $display("FAIL rand_deliver t=%0d rd_valid=%b rd_data=%h exp %b %h", t, rd_valid, rd_data, eg, b);
      end
      if (bad != 0 || nrd != 0 || grant !== '0) tx_err++;
      last_m = w;
    end
    checks++; if (tx_err != 0) begin errors++; $display("FAIL rand_hold bad_transactions=%0d exp=0", tx_err); end
    checks++; if (rd_eof !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL rand_flags eof=%b timeout=%b exp 0 0", rd_eof, timeout); end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int bad, lat;
    do_reset();
    src_mode = 3;
    req = 2'b01;
    @(negedge clk);
    checks++; if (grant !== 2'b01 || src_rd !== 1'b1) begin errors++; $display("FAIL to_grant grant=%b src_rd=%b exp 01 1", grant, src_rd); end
    bad = 0;
    for (int c = 1; c <= TIMEOUT; c++) begin
      @(negedge clk);
      if (timeout !== 1'b0 || rd_valid !== '0 || src_rd !== 1'b0 || grant !== 2'b01) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL to_wait bad_cycles=%0d exp=0", bad); end
    src_mode = 0; src_delay = 1; src_byte = 8'h5A;
    @(negedge clk);
    checks++; if (timeout !== 1'b1 || grant !== 2'b00 || rd_valid !== 2'b00) begin
      errors++; $display("FAIL to_fire timeout=%b grant=%b rd_valid=%b exp 1 00 00", timeout, grant, rd_valid);
    end
    req = 2'b11;  // the timed-out owner must win again
    @(negedge clk);
    checks++; if (grant !== 2'b01 || src_rd !== 1'b1) begin errors++; $display("FAIL to_regrant grant=%b src_rd=%b exp 01 1", grant, src_rd); end
    req = 2'b00;
    lat = 0;
    do begin @(negedge clk); lat++; end while (rd_valid === '0 && lat < TIMEOUT + 4);
    checks++; if (rd_valid !== 2'b01 || rd_data !== 8'h5A || timeout !== 1'b1) begin
      errors++; $display("FAIL to_retry rd_valid=%b rd_data=%h timeout=%b exp 01 5a 1", rd_valid, rd_data, timeout);
    end
  endtask

  task automatic test_eof_only();
    int bad, lat;
    do_reset();
    src_mode = 1; src_delay = $urandom_range(0, 4); src_byte = 8'h00;
    req = 2'b10;
    @(negedge clk);
    checks++; if (grant !== 2'b10 || rd_eof !== 1'b0) begin errors++; $display("FAIL eof_grant grant=%b rd_eof=%b exp 10 0", grant, rd_eof); end
    req = 2'b00;
    lat = 0;
    do begin @(negedge clk); lat++; end while (rd_valid === '0 && lat < TIMEOUT + 4);
    checks++; if (rd_valid !== 2'b10 || rd_data !== 8'hFF || rd_eof !== 1'b1 || grant !== 2'b00) begin
      errors++; $display("FAIL eof_deliver rd_valid=%b rd_data=%h rd_eof=%b grant=%b exp 10 ff 1 00", rd_valid, rd_data, rd_eof, grant);
    end
    req = 2'b11;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (grant !== '0 || src_rd !== 1'b0 || rd_valid !== '0 || rd_eof !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL eof_terminal bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_data_eof();
    int bad, lat;
    do_reset();
    src_mode = 2; src_delay = 0; src_byte = 8'h0A;
    req = 2'b01;
    @(negedge clk);
    req = 2'b00;
    lat = 0;
    do begin @(negedge clk); lat++; end while (rd_valid === '0 && lat < TIMEOUT + 4);
    checks++; if (rd_valid !== 2'b01 || rd_data !== 8'h0A || rd_eof !== 1'b1) begin
      errors++; $display("FAIL deof_deliver rd_valid=%b rd_data=%h rd_eof=%b exp 01 0a 1", rd_valid, rd_data, rd_eof);
    end
    req = 2'b11;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (grant !== '0 || src_rd !== 1'b0 || rd_eof !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL deof_terminal bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_reset_mid_wait();
    int bad, lat;
    do_reset();
    src_mode = 0; src_delay = 6; src_byte = 8'h77;
    req = 2'b10;
    @(negedge clk);
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL rmw_grant grant=%b exp 10", grant); end
    req = 2'b00;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (grant !== '0 || rd_valid !== '0 || rd_data !== 8'h00 || src_rd !== 1'b0 || rd_eof !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL rmw_async grant=%b rd_valid=%b rd_data=%h src_rd=%b eof=%b to=%b exp all 0",
                         grant, rd_valid, rd_data, src_rd, rd_eof, timeout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (rd_valid !== '0 || grant !== '0 || src_rd !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rmw_late_valid bad_cycles=%0d exp=0", bad); end
    src_mode = 0; src_delay = 0; src_byte = 8'h33;
    req = 2'b11;
    @(negedge clk);
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rmw_last_reset grant=%b exp 01", grant); end
    req = 2'b00;
    lat = 0;
    do begin @(negedge clk); lat++; end while (rd_valid === '0 && lat < TIMEOUT + 4);
    checks++; if (rd_valid !== 2'b01 || rd_data !== 8'h33) begin
      errors++; $display("FAIL rmw_recover rd_valid=%b rd_data=%h exp 01 33", rd_valid, rd_data);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_random(40);
    test_timeout();
    test_eof_only();
    test_data_eof();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
